// File: rtl/magnetron_countdown_timer_pkg.sv
// Shared definitions for the magnetron cooking-time countdown.
// Contents: BCD digit width, per-digit limits, packed mm:ss time type, ZERO_TIME.
package magnetron_countdown_timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIG_MAX_U  = 4'd9;  // units of minutes/seconds
  localparam logic [DIGIT_W-1:0] DIG_MAX_ST = 4'd5;  // tens of seconds
  localparam int                 MAX_MIN_T_DEF = 9;  // default tens-of-minutes limit

  typedef struct packed {
    logic [DIGIT_W-1:0] min_t;
    logic [DIGIT_W-1:0] min_u;
    logic [DIGIT_W-1:0] sec_t;
    logic [DIGIT_W-1:0] sec_u;
  } mmss_t;

  localparam mmss_t ZERO_TIME = '0;

endpackage

// File: rtl/magnetron_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with clamped load and borrow chaining.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         zero the digit (priority over load/dec)
//   load          capture ld_val, clamped to max_val
//   dec           borrow_in: decrement this digit by one
//   max_val       largest legal value; also the value taken on 0 -> borrow
//   ld_val        value to load
//   digit         registered digit
//   nxt           value the digit takes on the next edge
//   borrow_out    this digit wrapped from 0, next digit must decrement
//   is_zero       digit currently 0
module magnetron_countdown_timer_bcd_down_digit
  import magnetron_countdown_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] max_val,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] nxt,
  output logic               borrow_out,
  output logic               is_zero
);

  assign is_zero    = (digit == '0);
  assign borrow_out = dec & is_zero;

  always_comb begin
    nxt = digit;
    if (clear)
      nxt = '0;
    else if (load)
      nxt = (ld_val > max_val) ? max_val : ld_val;
    else if (dec)
      nxt = is_zero ? max_val : digit - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) digit <= '0;
    else     digit <= nxt;
  end

endmodule

// File: rtl/magnetron_countdown_timer.sv
// Cooking-time countdown feeding the magnetron set/reset logic.
// Holds an mm:ss BCD time loaded from the keypad, counts it down once per
// second while enable (magnetron on) is high, and raises tdone at 00:00.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   clear                        zero the time (from limpaN low)
//   load, ld_min_t..ld_sec_u     keypad load pulse and BCD digits
//   enable                       magnetron energised; gates counting
//   min_t, min_u, sec_t, sec_u   registered BCD time
//   tdone                        registered, high while time is 00:00
//   tick                         one-cycle pulse on each decrement edge
module magnetron_countdown_timer
  import magnetron_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_MIN_T = MAX_MIN_T_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_min_t,
  input  logic [DIGIT_W-1:0] ld_min_u,
  input  logic [DIGIT_W-1:0] ld_sec_t,
  input  logic [DIGIT_W-1:0] ld_sec_u,
  input  logic               enable,
  output logic [DIGIT_W-1:0] min_t,
  output logic [DIGIT_W-1:0] min_u,
  output logic [DIGIT_W-1:0] sec_t,
  output logic [DIGIT_W-1:0] sec_u,
  output logic               tdone,
  output logic               tick
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Index 0 = sec_u ... 3 = min_t, so the borrow chain runs upward.
  logic [3:0][DIGIT_W-1:0] ld_v, max_v, dig, nxt;
  logic [3:0]              dec, borrow, zero;
  logic [PW-1:0]           pre;
  logic                    time_zero, tick_now;
  mmss_t                   cur_time, nxt_time;

  assign ld_v  = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
  assign max_v = {DIGIT_W'(MAX_MIN_T), DIG_MAX_U, DIG_MAX_ST, DIG_MAX_U};

  assign time_zero = &zero;
  // clear and load both outrank the decrement, so they suppress the tick.
  assign tick_now  = enable & ~time_zero & (pre == PRE_LAST) & ~clear & ~load;
  assign dec       = {borrow[2:0], tick_now};

  for (genvar i = 0; i < 4; i++) begin : g_dig
    magnetron_countdown_timer_bcd_down_digit u_dig (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .load       (load),
      .dec        (dec[i]),
      .max_val    (max_v[i]),
      .ld_val     (ld_v[i]),
      .digit      (dig[i]),
      .nxt        (nxt[i]),
      .borrow_out (borrow[i]),
      .is_zero    (zero[i])
    );
  end

  assign cur_time = dig;
  assign nxt_time = nxt;
  assign min_t = cur_time.min_t;
  assign min_u = cur_time.min_u;
  assign sec_t = cur_time.sec_t;
  assign sec_u = cur_time.sec_u;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      tick  <= 1'b0;
      tdone <= 1'b1;
    end else begin
      tick <= tick_now;
      // A borrow out of min_t would mean running below 00:00; the decrement
      // is gated at zero so it never fires, but it would still mean done.
      tdone <= (nxt_time == ZERO_TIME) | borrow[3];
      if (clear || load || time_zero)
        pre <= '0;
      else if (enable)
        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      // enable low: hold the partial second across a pause
    end
  end

endmodule
